sramlike_axi_bridge: RTL and testbench

Bridges the instruction-cache and data-cache SRAM-like request ports onto a single AXI4 master. Sits directly downstream of the instruction cache (and the data cache) and upstream of the SoC AXI interconnect. Arbitrates round-robin between the two ports, with one transaction outstanding at a time. Issues single-beat AXI reads and writes and returns completion on the originating port's `data_ok`.

---
 rtl/axi_pkg.sv | 39 +++
 rtl/axi_wstrb_gen.sv | 21 ++
 rtl/sramlike_axi_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared constants, FSM states and request payload for the SRAM-like to AXI4 bridge.
package axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [7:0] LEN_SINGLE  = 8'd0;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'b0000;
    localparam logic [2:0] PROT_NONE   = 3'b000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe for a single-beat write from access size and low address bits.
module axi_wstrb_gen
    import axi_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    output logic [STRB_W-1:0] wstrb
);

    // Size 3 is not a legal SRAM-like size; it falls back to a full word.
    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'(4'b0001 << addr_lo);
            SIZE_HALF: wstrb = 4'(4'b0011 << addr_lo);
            SIZE_WORD: wstrb = 4'b1111;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Round-robin bridge from the inst/data SRAM-like ports onto one AXI4 master,
// one single-beat transaction in flight at a time.
module sramlike_axi_bridge
    import axi_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,

    output logic [ID_WIDTH-1:0] arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,

    input  logic [ID_WIDTH-1:0] rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_WIDTH-1:0] awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,

    output logic [ID_WIDTH-1:0] wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [STRB_W-1:0]   wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_t            state;
    port_t             sel;
    port_t             last_grant;
    sram_req_t         req_q;
    sram_req_t         grant_req;
    logic [DATA_W-1:0] rdata_q;
    logic [STRB_W-1:0] grant_strb;
    logic              aw_done;
    logic              w_done;
    logic              aw_hs;
    logic              w_hs;
    logic              grant_inst;
    logic              grant_data;

    // Responses and IDs carry nothing the requesters can use.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    // Arbitration: a tie goes to the port that was not granted last.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE) begin
            if (inst_req && data_req) begin
                grant_data = (last_grant == PORT_INST);
                grant_inst = (last_grant == PORT_DATA);
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    assign grant_req = grant_data ? '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata}
                                  : '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};

    axi_wstrb_gen u_wstrb_gen (
        .size    (grant_req.size),
        .addr_lo (grant_req.addr[1:0]),
        .wstrb   (grant_strb)
    );

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Channel payloads come straight from the latched request.
    assign arid    = ID_WIDTH'(0);
    assign arlen   = LEN_SINGLE;
    assign arsize  = {1'b0, req_q.size};
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_NORMAL;
    assign arcache = CACHE_NONE;
    assign arprot  = PROT_NONE;
    assign araddr  = req_q.addr;

    assign awid    = ID_WIDTH'(0);
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, req_q.size};
    assign awburst = BURST_INCR;
    assign awlock  = LOCK_NORMAL;
    assign awcache = CACHE_NONE;
    assign awprot  = PROT_NONE;
    assign awaddr  = req_q.addr;

    assign wid   = ID_WIDTH'(0);
    assign wdata = req_q.wdata;
    assign wlast = 1'b1;

    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= PORT_INST;
            last_grant   <= PORT_INST;
            req_q        <= '0;
            rdata_q      <= '0;
            wstrb        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_inst || grant_data) begin
                        sel        <= grant_data ? PORT_DATA : PORT_INST;
                        last_grant <= grant_data ? PORT_DATA : PORT_INST;
                        req_q      <= grant_req;
                        wstrb      <= grant_strb;
                        if (grant_req.wr) begin
                            state   <= WR_ADDR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready       <= 1'b0;
                        rdata_q      <= rdata;
                        inst_data_ok <= (sel == PORT_INST);
                        data_data_ok <= (sel == PORT_DATA);
                        state        <= DONE;
                    end
                end
                // AW and W complete independently, in any order.
                WR_ADDR: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs)  wvalid  <= 1'b0;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_RESP;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready       <= 1'b0;
                        inst_data_ok <= (sel == PORT_INST);
                        data_data_ok <= (sel == PORT_DATA);
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Randomized bench for sramlike_axi_bridge: the bench plays both requesters and the
// AXI slave, and a transaction-level model predicts every handshake and completion.
module tb_sramlike_axi_bridge;

    localparam int unsigned IDW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]      inst_size;
    logic [31:0]     inst_addr, inst_wdata, inst_rdata;
    logic            data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]      data_size;
    logic [31:0]     data_addr, data_wdata, data_rdata;
    logic [IDW-1:0]  arid, rid, awid, wid, bid;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, arprot, awsize, awprot;
    logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sramlike_axi_bridge #(.ID_WIDTH(IDW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    // Requester side: one pending request per port, held until accepted.
    bit          p_req[2];
    bit          p_wr[2];
    logic [1:0]  p_size[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];

    int unsigned req_prob, wr_prob, ar_prob, r_prob, aw_prob, w_prob, b_prob;
    bit          want_rst;
    bit          zero_wait;
    bit          fixed_rd;
    logic [31:0] fixed_rdata;

    // Transaction-level model of the bridge.
    bit          busy, ok_due, last_data;
    int          port;
    bit          t_wr;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata, t_rdata;
    bit          ar_done, r_done, aw_done, w_done, b_done;
    int unsigned grant_cyc;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit roll(int unsigned pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    function automatic logic [3:0] exp_strb(logic [1:0] s, logic [1:0] a);
        int unsigned m;
        if (s == 2'd0)      m = 1 << a;
        else if (s == 2'd1) m = 3 << a;
        else                m = 15;
        return 4'(m & 15);
    endfunction

    task automatic set_probs(int unsigned p);
        ar_prob = p; r_prob = p; aw_prob = p; w_prob = p; b_prob = p;
    endtask

    task automatic issue(int p, bit wr, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        p_req[p] = 1'b1; p_wr[p] = wr; p_size[p] = sz; p_addr[p] = a; p_wdata[p] = d;
    endtask

    task automatic observe();
        int win;
        bit e_arv, e_rr, e_awv, e_wv, e_br;
        win = -1;
        if (!busy) begin
            if (p_req[0] && p_req[1]) win = last_data ? 0 : 1;
            else if (p_req[0])        win = 0;
            else if (p_req[1])        win = 1;
        end
        e_arv = busy && !t_wr && !ar_done;
        e_rr  = busy && !t_wr && ar_done && !r_done;
        e_awv = busy && t_wr && !aw_done;
        e_wv  = busy && t_wr && !w_done;
        e_br  = busy && t_wr && aw_done && w_done && !b_done;

        check("inst_addr_ok", 32'(inst_addr_ok), 32'(win == 0));
        check("data_addr_ok", 32'(data_addr_ok), 32'(win == 1));
        check("arvalid", 32'(arvalid), 32'(e_arv));
        check("rready",  32'(rready),  32'(e_rr));
        check("awvalid", 32'(awvalid), 32'(e_awv));
        check("wvalid",  32'(wvalid),  32'(e_wv));
        check("bready",  32'(bready),  32'(e_br));
        check("inst_data_ok", 32'(inst_data_ok), 32'(ok_due && port == 0));
        check("data_data_ok", 32'(data_data_ok), 32'(ok_due && port == 1));

        if (e_arv) begin
            check("araddr", araddr, t_addr);
            check("arsize", 32'(arsize), 32'(t_size));
            check("ar_fixed", 32'({arid, arlen, arburst, arlock, arcache, arprot}),
                  32'({4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
        end
        if (e_awv) begin
            check("awaddr", awaddr, t_addr);
            check("awsize", 32'(awsize), 32'(t_size));
            check("aw_fixed", 32'({awid, awlen, awburst, awlock, awcache, awprot}),
                  32'({4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
        end
        if (e_wv) begin
            check("wdata", wdata, t_wdata);
            check("wstrb", 32'(wstrb), 32'(exp_strb(t_size, t_addr[1:0])));
            check("wlast_wid", 32'({wlast, wid}), 32'({1'b1, 4'd0}));
        end
        if (ok_due && !t_wr)
            check("rdata", (port == 0) ? inst_rdata : data_rdata, t_rdata);
        if (ok_due && zero_wait)
            check("latency", cyc - grant_cyc, 32'd3);

        if (rst) begin
            busy = 0; ok_due = 0; last_data = 0;
            ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
        end else if (ok_due) begin
            ok_due = 0;
            busy   = 0;
        end else if (busy) begin
            if (!t_wr) begin
                if (e_arv && arready) ar_done = 1;
                else if (e_rr && rvalid) begin
                    r_done = 1; t_rdata = rdata; ok_due = 1;
                end
            end else begin
                if (e_br && bvalid) begin
                    b_done = 1; ok_due = 1;
                end
                if (e_awv && awready) aw_done = 1;
                if (e_wv && wready)   w_done  = 1;
            end
        end else if (win >= 0) begin
            busy = 1; port = win; last_data = (win == 1); grant_cyc = cyc;
            t_wr = p_wr[win]; t_size = p_size[win]; t_addr = p_addr[win]; t_wdata = p_wdata[win];
            ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
            p_req[win] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        rst = want_rst;
        for (int p = 0; p < 2; p++) begin
            if (!p_req[p] && !want_rst && roll(req_prob))
                issue(p, roll(wr_prob), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        inst_req = p_req[0]; inst_wr = p_wr[0]; inst_size = p_size[0];
        inst_addr = p_addr[0]; inst_wdata = p_wdata[0];
        data_req = p_req[1]; data_wr = p_wr[1]; data_size = p_size[1];
        data_addr = p_addr[1]; data_wdata = p_wdata[1];
        arready = roll(ar_prob);
        awready = roll(aw_prob);
        wready  = roll(w_prob);
        rvalid  = busy && !t_wr && ar_done && !r_done && !want_rst && roll(r_prob);
        rdata   = fixed_rd ? fixed_rdata : $urandom;
        rresp   = 2'($urandom_range(0, 3));
        rlast   = 1'b1;
        rid     = '0;
        bvalid  = busy && t_wr && aw_done && w_done && !b_done && !want_rst && roll(b_prob);
        bresp   = 2'($urandom_range(0, 3));
        bid     = '0;
        #1;
        observe();
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_prob = 0;
        set_probs(100);
        while ((busy || p_req[0] || p_req[1]) && n < 100) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(busy || p_req[0] || p_req[1]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; want_rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 0; p_wr[p] = 0; p_size[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
        end
        busy = 0; ok_due = 0; last_data = 0; port = 0; t_wr = 0; t_size = 0;
        t_addr = 0; t_wdata = 0; t_rdata = 0; grant_cyc = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
        req_prob = 0; wr_prob = 50; set_probs(100);
        zero_wait = 0; fixed_rd = 0; fixed_rdata = 0;

        repeat (3) @(negedge clk);
        step();
        want_rst = 1'b0;

        // Single inst read and byte write with zero-wait AXI.
        zero_wait = 1; fixed_rd = 1; fixed_rdata = 32'h2408_0001;
        issue(0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
        drain();
        issue(1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
        drain();
        zero_wait = 0; fixed_rd = 0;

        // W handshake well ahead of AW.
        aw_prob = 0;
        issue(1, 1'b1, 2'd2, $urandom, $urandom);
        repeat (5) step();
        drain();

        // AR backpressure while a data request arrives.
        ar_prob = 0;
        issue(0, 1'b0, 2'd1, $urandom, 32'h0);
        repeat (2) step();
        issue(1, 1'b0, 2'd2, $urandom, 32'h0);
        repeat (5) step();
        drain();

        // Both ports requesting continuously.
        set_probs(100); req_prob = 100;
        repeat (40) step();
        drain();

        // Random traffic with random backpressure.
        ar_prob = 60; r_prob = 50; aw_prob = 55; w_prob = 45; b_prob = 50;
        req_prob = 30; wr_prob = 50;
        repeat (2000) step();
        drain();

        // Reset while waiting for read data.
        r_prob = 0;
        issue(0, 1'b0, 2'd2, $urandom, 32'h0);
        n = 0;
        while (!(busy && !t_wr && ar_done) && n < 20) begin
            step();
            n++;
        end
        check("reach_rd_data", 32'(busy && !t_wr && ar_done), 32'd1);
        want_rst = 1'b1;
        step();
        want_rst = 1'b0;
        step();
        step();

        // Fresh tie after reset: data first, then inst.
        issue(0, 1'b0, 2'd2, $urandom, 32'h0);
        issue(1, 1'b0, 2'd2, $urandom, 32'h0);
        drain();

        ar_prob = 70; r_prob = 70; aw_prob = 70; w_prob = 70; b_prob = 70;
        req_prob = 50;
        repeat (300) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
